uc_dispatcher: RTL and testbench
================================

UC_DISPATCHER -- requirements
Module: uc_dispatcher

Interface
REQ-001 SHALL have parameter UC_LENGTH, default 1024, literal space size; LIT_W = $clog2(UC_LENGTH), literal = {var[LIT_W-1:1], pol[0]}, NUM_VAR = UC_LENGTH/2.
REQ-002 SHALL have parameter NUM_ENG, default 4, number of propagation engines served.
REQ-003 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ucq2ucd_valid  input  1  unit-clause queue has a literal at its head.
REQ-006 SHALL have port ucq2ucd_lit  input  LIT_W  head literal of unit-clause queue.
REQ-007 SHALL have port ucd2ucq_pop  output  1  pops queue head this cycle.
REQ-008 SHALL have port ucd2eng_valid  output  NUM_ENG  per-engine broadcast valid.
REQ-009 SHALL have port ucd2eng_lit  output  LIT_W  broadcast literal, common to all engines.
REQ-010 SHALL have port eng2ucd_ack  input  NUM_ENG  per-engine acceptance of the broadcast literal.
REQ-011 SHALL have port flush  input  1  synchronous clear of assignment table and FSM (backtrack/restart).
REQ-012 SHALL have port conflict  output  1  opposite-polarity unit literal detected.
REQ-013 SHALL have port conflict_lit  output  LIT_W  literal that caused the conflict.
REQ-014 SHALL have port bcast_cnt  output  16  number of literals broadcast since reset, wraps.

Function
REQ-015 SHALL implement FSM states IDLE, CHECK, BCAST, CONFLICT.
REQ-016 IDLE: ucq2ucd_valid=1 and flush=0 -> ucd2ucq_pop=1 same cycle (combinational), latch lit into lit_r, next CHECK; pop SHALL be 0 in every other state.
REQ-017 CHECK: table lookup of var(lit_r): unassigned -> write assigned=1, pol=pol(lit_r), next BCAST; assigned same polarity -> drop, next IDLE; assigned opposite -> next CONFLICT.
REQ-018 BCAST entry: pending mask = all ones; ucd2eng_valid = pending; ucd2eng_lit = lit_r, stable while any bit pending.
REQ-019 Engine i ack SHALL clear pending[i] only when pending[i]=1; acks on non-pending bits ignored; simultaneous acks from several engines all honoured in one cycle.
REQ-020 Last pending bit cleared -> bcast_cnt+1, next IDLE; minimum literal throughput 1 per 3 cycles (IDLE, CHECK, BCAST with same-cycle acks).
REQ-021 CONFLICT: conflict=1, conflict_lit=lit_r held, no pop, no broadcast, until flush.
REQ-022 flush=1 in any state: next state IDLE, pending cleared, all table entries unassigned, conflict=0 next cycle; flush takes priority over pop, ack and table write in that cycle.
REQ-023 bcast_cnt SHALL NOT be cleared by flush; wraps 0xFFFF -> 0x0000.
REQ-024 Variable 0 and variable NUM_VAR-1 SHALL be handled like any other index.

Reset
REQ-025 rst low SHALL asynchronously force state IDLE, lit_r=0, pending=0, table all unassigned, bcast_cnt=0.
REQ-026 Outputs during/after reset: ucd2ucq_pop=0, ucd2eng_valid=0, ucd2eng_lit=0, conflict=0, conflict_lit=0, bcast_cnt=0.
REQ-027 Reset asserted mid-broadcast SHALL abandon the literal; no partial broadcast resumes after release.

Structure
REQ-028 Shared package uc_pkg SHALL hold UC_LENGTH, NUM_ENG defaults, LIT_W, lit_t typedef, var/polarity extraction functions, and the dispatcher state enum.
REQ-029 Assignment table SHALL be sub-module uc_assign_table (NUM_VAR x {assigned, pol}, one read, one write, single-cycle clear).
REQ-030 Implementation SHALL be fully synchronous apart from asynchronous reset; no combinational path from eng2ucd_ack to ucd2ucq_pop.

Verification
REQ-031 Single literal: push 0x006, all engines ack first BCAST cycle -> pop in cycle 0, ucd2eng_valid=0xF with lit 0x006 in cycle 2, IDLE cycle 3, bcast_cnt=1.
REQ-032 Staggered acks: engines ack in cycles +0,+2,+2,+5 -> valid mask 0xF,0xE,0xE,0x8,0x8,0x8 then 0; lit held 0x006 throughout.
REQ-033 Duplicate: push 0x006 twice -> second popped, no broadcast, bcast_cnt stays 1.
REQ-034 Conflict: push 0x006 then 0x007 -> conflict=1, conflict_lit=0x007, queue not popped further; flush -> conflict=0, then 0x007 broadcast normally.
REQ-035 Flush mid-BCAST with ucq2ucd_valid=1 same cycle -> no pop that cycle, valid drops to 0, next cycle pops new head.
REQ-036 Async reset pulse mid-BCAST and bcast_cnt wrap after 65536 broadcasts -> all outputs 0 immediately; counter reads 0x0000 after wrap.

Source files
------------

// File: rtl/uc_pkg.sv
// Purpose: shared types, default sizes and literal helpers for the unit-clause dispatcher.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uc_pkg;

    localparam int UC_LENGTH_DEF = 1024;
    localparam int NUM_ENG_DEF   = 4;
    localparam int LIT_W         = $clog2(UC_LENGTH_DEF);

    // A literal is {variable index, polarity bit}.
    typedef logic [LIT_W-1:0] lit_t;

    typedef enum logic [1:0] {
        UCD_IDLE     = 2'd0,
        UCD_CHECK    = 2'd1,
        UCD_BCAST    = 2'd2,
        UCD_CONFLICT = 2'd3
    } ucd_state_t;

    // Helpers take a 32-bit zero-extended literal so they serve any UC_LENGTH.
    function automatic logic [31:0] lit_var(input logic [31:0] lit);
        return lit >> 1;
    endfunction

    function automatic logic lit_pol(input logic [31:0] lit);
        return (lit & 32'd1) != 32'd0;
    endfunction

endpackage

// File: rtl/uc_dispatcher_if.sv
// Purpose: queue-side and engine-side handshake bundle of the unit-clause dispatcher.
// Latency: n/a (wires only).
// Backpressure: queue pops on ucd2ucq_pop; engines hold off a broadcast by withholding eng2ucd_ack.
// Modports: master = dispatcher side, slave = queue/engine side.
interface uc_dispatcher_if #(
    parameter int LIT_W   = uc_pkg::LIT_W,
    parameter int NUM_ENG = uc_pkg::NUM_ENG_DEF
);
    logic               ucq2ucd_valid;
    logic [LIT_W-1:0]   ucq2ucd_lit;
    logic               ucd2ucq_pop;
    logic [NUM_ENG-1:0] ucd2eng_valid;
    logic [LIT_W-1:0]   ucd2eng_lit;
    logic [NUM_ENG-1:0] eng2ucd_ack;

    modport master (
        input  ucq2ucd_valid,
        input  ucq2ucd_lit,
        input  eng2ucd_ack,
        output ucd2ucq_pop,
        output ucd2eng_valid,
        output ucd2eng_lit
    );

    modport slave (
        output ucq2ucd_valid,
        output ucq2ucd_lit,
        output eng2ucd_ack,
        input  ucd2ucq_pop,
        input  ucd2eng_valid,
        input  ucd2eng_lit
    );
endinterface

// File: rtl/uc_assign_table.sv
// Purpose: per-variable {assigned, polarity} table, one async read port, one write port, one-cycle clear.
// Latency: read combinational; write and clear visible the cycle after.
// Backpressure: none, always ready.
// Ports: clk/rst, clr (sync clear of all assigned flags), rd_idx -> rd_assigned/rd_pol, wr_en/wr_idx/wr_pol.
module uc_assign_table #(
    parameter int NUM_VAR = 512,
    parameter int VAR_W   = $clog2(NUM_VAR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [VAR_W-1:0] rd_idx,
    output logic             rd_assigned,
    output logic             rd_pol,
    input  logic             wr_en,
    input  logic [VAR_W-1:0] wr_idx,
    input  logic             wr_pol
);

    logic [NUM_VAR-1:0] assigned_q;
    logic [NUM_VAR-1:0] pol_q;

    // Only the assigned flags need clearing; polarity is don't-care while unassigned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            assigned_q <= '0;
        end else if (clr) begin
            assigned_q <= '0;
        end else if (wr_en) begin
            assigned_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !clr) begin
            pol_q[wr_idx] <= wr_pol;
        end
    end

    assign rd_assigned = assigned_q[rd_idx];
    assign rd_pol      = pol_q[rd_idx];

endmodule

// File: rtl/uc_dispatcher.sv
// Purpose: pops unit literals, filters duplicates/conflicts via the assignment table, broadcasts new ones to all engines.
// Latency: pop in IDLE, table check next cycle, broadcast the cycle after (1 literal per 3 cycles best case).
// Backpressure: broadcast holds until every engine has acked; no pop while checking, broadcasting or in conflict.
// Ports: clk/rst, bus (queue + engine handshake), flush (sync clear), conflict/conflict_lit, bcast_cnt.
module uc_dispatcher #(
    parameter  int UC_LENGTH = uc_pkg::UC_LENGTH_DEF,
    parameter  int NUM_ENG   = uc_pkg::NUM_ENG_DEF,
    localparam int LIT_W     = $clog2(UC_LENGTH),
    localparam int NUM_VAR   = UC_LENGTH / 2,
    localparam int VAR_W     = LIT_W - 1
) (
    input  logic              clk,
    input  logic              rst,
    uc_dispatcher_if.master   bus,
    input  logic              flush,
    output logic              conflict,
    output logic [LIT_W-1:0]  conflict_lit,
    output logic [15:0]       bcast_cnt
);
    import uc_pkg::*;

    ucd_state_t         state_q, state_d;
    logic [LIT_W-1:0]   lit_r;
    logic [NUM_ENG-1:0] pending_q, pending_d;
    logic [15:0]        bcast_cnt_q;

    logic               pop;
    logic               lit_ld;
    logic               cnt_inc;
    logic               tbl_wr;
    logic [VAR_W-1:0]   var_idx;
    logic               lit_pol_r;
    logic               rd_assigned;
    logic               rd_pol;

    assign var_idx   = VAR_W'(lit_var(32'(lit_r)));
    assign lit_pol_r = lit_pol(32'(lit_r));

    uc_assign_table #(
        .NUM_VAR (NUM_VAR),
        .VAR_W   (VAR_W)
    ) u_table (
        .clk         (clk),
        .rst         (rst),
        .clr         (flush),
        .rd_idx      (var_idx),
        .rd_assigned (rd_assigned),
        .rd_pol      (rd_pol),
        .wr_en       (tbl_wr),
        .wr_idx      (var_idx),
        .wr_pol      (lit_pol_r)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= UCD_IDLE;
            lit_r       <= '0;
            pending_q   <= '0;
            bcast_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            if (lit_ld) begin
                lit_r <= bus.ucq2ucd_lit;
            end
            if (cnt_inc) begin
                bcast_cnt_q <= bcast_cnt_q + 16'd1;
            end
        end
    end

    // Flush overrides everything: no pop, no table write, no ack bookkeeping.
    // Pop depends only on state, queue valid and flush, never on engine acks.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        pop       = 1'b0;
        lit_ld    = 1'b0;
        cnt_inc   = 1'b0;
        tbl_wr    = 1'b0;
        if (flush) begin
            state_d   = UCD_IDLE;
            pending_d = '0;
        end else begin
            unique case (state_q)
                UCD_IDLE: begin
                    if (bus.ucq2ucd_valid) begin
                        pop     = 1'b1;
                        lit_ld  = 1'b1;
                        state_d = UCD_CHECK;
                    end
                end
                UCD_CHECK: begin
                    if (!rd_assigned) begin
                        tbl_wr    = 1'b1;
                        pending_d = '1;
                        state_d   = UCD_BCAST;
                    end else if (rd_pol == lit_pol_r) begin
                        state_d = UCD_IDLE;
                    end else begin
                        state_d = UCD_CONFLICT;
                    end
                end
                UCD_BCAST: begin
                    // Acks on already-cleared bits fall out of the AND.
                    pending_d = pending_q & ~bus.eng2ucd_ack;
                    if (pending_d == '0) begin
                        cnt_inc = 1'b1;
                        state_d = UCD_IDLE;
                    end
                end
                UCD_CONFLICT: begin
                    state_d = UCD_CONFLICT;
                end
                default: begin
                    state_d   = UCD_IDLE;
                    pending_d = '0;
                end
            endcase
        end
    end

    assign bus.ucd2ucq_pop   = pop;
    assign bus.ucd2eng_valid = (state_q == UCD_BCAST) ? pending_q : '0;
    assign bus.ucd2eng_lit   = (state_q == UCD_BCAST) ? lit_r : '0;
    assign conflict          = (state_q == UCD_CONFLICT);
    assign conflict_lit      = (state_q == UCD_CONFLICT) ? lit_r : '0;
    assign bcast_cnt         = bcast_cnt_q;

endmodule

// File: tb/tb_uc_dispatcher.sv
module tb_uc_dispatcher;

    localparam int LW = 10;
    localparam int NE = 4;
    localparam int NV = 512;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          conflict;
    logic [LW-1:0] conflict_lit;
    logic [15:0]   bcast_cnt;

    uc_dispatcher_if #(.LIT_W(LW), .NUM_ENG(NE)) bus ();

    uc_dispatcher #(.UC_LENGTH(1024), .NUM_ENG(NE)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .flush        (flush),
        .conflict     (conflict),
        .conflict_lit (conflict_lit),
        .bcast_cnt    (bcast_cnt)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: what the dispatcher should know about each variable.
    bit          m_asg [NV];
    bit          m_pol [NV];
    logic [15:0] m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_clear();
        foreach (m_asg[i]) m_asg[i] = 1'b0;
    endtask

    // Inputs change just after the falling edge; checks run 1 time unit later.
    task automatic drive(input bit v, input logic [LW-1:0] lit, input logic [NE-1:0] ack, input bit fl);
        @(negedge clk);
        bus.ucq2ucd_valid = v;
        bus.ucq2ucd_lit   = lit;
        bus.eng2ucd_ack   = ack;
        flush             = fl;
        #1;
    endtask

    // One literal through the dispatcher, outcome predicted from the model.
    task automatic run_lit(input logic [LW-1:0] lit, input bit rnd_ack);
        int          v;
        bit          p;
        logic [NE-1:0] pend;
        logic [NE-1:0] a;
        v = int'(lit >> 1);
        p = lit[0];
        drive(1'b1, lit, '0, 1'b0);
        chk("pop_idle", 32'(bus.ucd2ucq_pop), 32'd1);
        drive(1'b0, '0, '0, 1'b0);
        chk("check_nopop", 32'(bus.ucd2ucq_pop), 32'd0);
        chk("check_noval", 32'(bus.ucd2eng_valid), 32'd0);
        if (!m_asg[v]) begin
            m_asg[v] = 1'b1;
            m_pol[v] = p;
            pend = '1;
            for (int c = 0; c < 40 && pend != '0; c++) begin
                a = (rnd_ack && c < 30) ? NE'($urandom_range(0, 15)) : '1;
                drive(1'b0, '0, a, 1'b0);
                chk("bc_valid", 32'(bus.ucd2eng_valid), 32'(pend));
                chk("bc_lit", 32'(bus.ucd2eng_lit), 32'(lit));
                pend = pend & ~a;
            end
            m_cnt = m_cnt + 16'd1;
            drive(1'b0, '0, '0, 1'b0);
            chk("bc_end_valid", 32'(bus.ucd2eng_valid), 32'd0);
            chk("bc_cnt", 32'(bcast_cnt), 32'(m_cnt));
        end else if (m_pol[v] == p) begin
            drive(1'b0, '0, '0, 1'b0);
            chk("dup_noval", 32'(bus.ucd2eng_valid), 32'd0);
            chk("dup_nocf", 32'(conflict), 32'd0);
            chk("dup_cnt", 32'(bcast_cnt), 32'(m_cnt));
        end else begin
            drive(1'b1, lit, '0, 1'b0);
            chk("cf_flag", 32'(conflict), 32'd1);
            chk("cf_lit", 32'(conflict_lit), 32'(lit));
            chk("cf_nopop", 32'(bus.ucd2ucq_pop), 32'd0);
            chk("cf_noval", 32'(bus.ucd2eng_valid), 32'd0);
            drive(1'b1, lit, '0, 1'b1);
            chk("cf_flush_nopop", 32'(bus.ucd2ucq_pop), 32'd0);
            model_clear();
            drive(1'b0, '0, '0, 1'b0);
            chk("cf_cleared", 32'(conflict), 32'd0);
        end
    endtask

    logic [NE-1:0] st_ack [6];
    logic [NE-1:0] st_exp [6];

    initial begin
        int          var_i;
        logic [LW-1:0] rl;

        rst               = 1'b0;
        flush             = 1'b0;
        bus.ucq2ucd_valid = 1'b0;
        bus.ucq2ucd_lit   = '0;
        bus.eng2ucd_ack   = '0;
        model_clear();
        m_cnt = '0;

        // Reset state
        #1;
        chk("rst_pop", 32'(bus.ucd2ucq_pop), 32'd0);
        chk("rst_valid", 32'(bus.ucd2eng_valid), 32'd0);
        chk("rst_lit", 32'(bus.ucd2eng_lit), 32'd0);
        chk("rst_conflict", 32'(conflict), 32'd0);
        chk("rst_conflict_lit", 32'(conflict_lit), 32'd0);
        chk("rst_cnt", 32'(bcast_cnt), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Single literal, all engines ack in the first broadcast cycle
        drive(1'b1, 10'h006, '0, 1'b0);
        chk("t1_pop", 32'(bus.ucd2ucq_pop), 32'd1);
        chk("t1_c0_valid", 32'(bus.ucd2eng_valid), 32'd0);
        drive(1'b0, '0, '0, 1'b0);
        chk("t1_c1_pop", 32'(bus.ucd2ucq_pop), 32'd0);
        chk("t1_c1_valid", 32'(bus.ucd2eng_valid), 32'd0);
        drive(1'b0, '0, 4'hF, 1'b0);
        chk("t1_c2_valid", 32'(bus.ucd2eng_valid), 32'hF);
        chk("t1_c2_lit", 32'(bus.ucd2eng_lit), 32'h006);
        drive(1'b1, 10'h00A, '0, 1'b1);
        chk("t1_c3_valid", 32'(bus.ucd2eng_valid), 32'd0);
        chk("t1_c3_cnt", 32'(bcast_cnt), 32'd1);
        m_cnt = 16'd1;

        // Staggered acks (previous step flushed the table)
        st_ack = '{4'h1, 4'h0, 4'h6, 4'h0, 4'h0, 4'h8};
        st_exp = '{4'hF, 4'hE, 4'hE, 4'h8, 4'h8, 4'h8};
        drive(1'b1, 10'h006, '0, 1'b0);
        chk("t2_pop", 32'(bus.ucd2ucq_pop), 32'd1);
        drive(1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, '0, st_ack[i], 1'b0);
            chk("t2_valid", 32'(bus.ucd2eng_valid), 32'(st_exp[i]));
            chk("t2_lit", 32'(bus.ucd2eng_lit), 32'h006);
        end
        drive(1'b0, '0, '0, 1'b0);
        chk("t2_end_valid", 32'(bus.ucd2eng_valid), 32'd0);
        chk("t2_cnt", 32'(bcast_cnt), 32'd2);
        m_cnt = 16'd2;
        m_asg[3] = 1'b1;
        m_pol[3] = 1'b0;

        // Duplicate literal
        run_lit(10'h006, 1'b0);

        // Conflict, held while the queue still offers a head, then flush and retry
        drive(1'b1, 10'h007, '0, 1'b0);
        chk("t4_pop", 32'(bus.ucd2ucq_pop), 32'd1);
        drive(1'b1, 10'h007, '0, 1'b0);
        chk("t4_check_nopop", 32'(bus.ucd2ucq_pop), 32'd0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 10'h007, '0, 1'b0);
            chk("t4_conflict", 32'(conflict), 32'd1);
            chk("t4_conflict_lit", 32'(conflict_lit), 32'h007);
            chk("t4_hold_nopop", 32'(bus.ucd2ucq_pop), 32'd0);
        end
        drive(1'b1, 10'h007, '0, 1'b1);
        chk("t4_flush_nopop", 32'(bus.ucd2ucq_pop), 32'd0);
        drive(1'b1, 10'h007, '0, 1'b0);
        chk("t4_after_conflict", 32'(conflict), 32'd0);
        chk("t4_after_conflict_lit", 32'(conflict_lit), 32'd0);
        chk("t4_repop", 32'(bus.ucd2ucq_pop), 32'd1);
        drive(1'b0, '0, '0, 1'b0);
        drive(1'b0, '0, 4'hF, 1'b0);
        chk("t4_bc_valid", 32'(bus.ucd2eng_valid), 32'hF);
        chk("t4_bc_lit", 32'(bus.ucd2eng_lit), 32'h007);
        drive(1'b0, '0, '0, 1'b0);
        chk("t4_cnt", 32'(bcast_cnt), 32'd3);

        // Flush mid-broadcast with a new head waiting; top variable index
        drive(1'b1, 10'h3FF, '0, 1'b0);
        drive(1'b0, '0, '0, 1'b0);
        drive(1'b0, '0, '0, 1'b0);
        chk("t5_valid", 32'(bus.ucd2eng_valid), 32'hF);
        chk("t5_lit", 32'(bus.ucd2eng_lit), 32'h3FF);
        drive(1'b1, 10'h000, 4'h3, 1'b1);
        chk("t5_flush_nopop", 32'(bus.ucd2ucq_pop), 32'd0);
        drive(1'b1, 10'h000, '0, 1'b0);
        chk("t5_valid_drop", 32'(bus.ucd2eng_valid), 32'd0);
        chk("t5_pop_new", 32'(bus.ucd2ucq_pop), 32'd1);
        chk("t5_cnt_kept", 32'(bcast_cnt), 32'd3);
        drive(1'b0, '0, '0, 1'b0);
        drive(1'b0, '0, 4'hF, 1'b0);
        chk("t5_var0_valid", 32'(bus.ucd2eng_valid), 32'hF);
        chk("t5_var0_lit", 32'(bus.ucd2eng_lit), 32'h000);
        drive(1'b0, '0, '0, 1'b0);
        chk("t5_cnt", 32'(bcast_cnt), 32'd4);
        model_clear();
        m_asg[0] = 1'b1;
        m_pol[0] = 1'b0;
        m_cnt = 16'd4;
        run_lit(10'h3FF, 1'b1);
        run_lit(10'h001, 1'b0);

        // Asynchronous reset in the middle of a broadcast
        drive(1'b1, 10'h002, '0, 1'b0);
        drive(1'b0, '0, '0, 1'b0);
        drive(1'b0, '0, '0, 1'b0);
        chk("t6_valid", 32'(bus.ucd2eng_valid), 32'hF);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(bus.ucd2eng_valid), 32'd0);
        chk("t6_rst_lit", 32'(bus.ucd2eng_lit), 32'd0);
        chk("t6_rst_pop", 32'(bus.ucd2ucq_pop), 32'd0);
        chk("t6_rst_conflict", 32'(conflict), 32'd0);
        chk("t6_rst_cnt", 32'(bcast_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        model_clear();
        m_cnt = '0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, '0, '0, 1'b0);
            chk("t6_no_resume", 32'(bus.ucd2eng_valid), 32'd0);
        end
        run_lit(10'h002, 1'b0);

        // Counter wrap: preload near the top instead of 65536 real broadcasts
        @(negedge clk);
        force dut.bcast_cnt_q = 16'hFFFE;
        #1;
        release dut.bcast_cnt_q;
        m_cnt = 16'hFFFE;
        chk("wrap_preload", 32'(bcast_cnt), 32'hFFFE);
        run_lit(10'h004, 1'b1);
        run_lit(10'h004, 1'b0);
        run_lit(10'h008, 1'b1);
        chk("wrap_zero", 32'(bcast_cnt), 32'h0000);

        // Randomized literals over a small variable set plus both boundary indices
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 4) == 0)
                var_i = ($urandom_range(0, 1) == 1) ? NV - 1 : 0;
            else
                var_i = int'($urandom_range(1, 8));
            rl = {9'(var_i), 1'($urandom_range(0, 1))};
            run_lit(rl, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
